mvm_avalon_loader: RTL and testbench



---
 rtl/mvm_avalon_loader.sv | 180 ++++++++++++++++++
 tb/tb_mvm_avalon_loader.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mvm_avalon_loader.sv
// mvm_avalon_loader
// Avalon-MM read master. It fetches an NxN byte matrix A (words 0..N-1) and
// an N-byte vector B (word N) from memory. It then streams them byte by byte
// into the fill interface of the matrix-vector unit: row i goes to A FIFO i,
// and the vector goes to the B FIFO.
//
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   start               one-cycle load request, honoured only in IDLE
//   busy, done          busy from the cycle after start; done pulses once at the end
//   avm_*               Avalon-MM read master (one read outstanding at a time)
//   a_wren/a_data/a_full  A FIFO fill lanes (one-hot strobe, per-lane data)
//   b_wren/b_data/b_full  B FIFO fill port
//   state_dbg           current FSM state
//                       (0 IDLE, 1 REQ, 2 WAIT, 3 PUSH, 4 DONE)
//
// Handshakes:
//   - A read is accepted on an edge where avm_read=1 and avm_waitrequest=0.
//     Until then, address and read stay frozen.
//   - Data is taken only on an edge where avm_readdatavalid=1 while in WAIT.
//   - A FIFO byte is written only when the full flag sampled on the previous
//     edge was 0. The strobe and data are registered, so they appear the
//     cycle after that edge.
module mvm_avalon_loader #(
    parameter int                    ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
    parameter int                    N          = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] avm_address,
    output logic                  avm_read,
    input  logic [8*N-1:0]        avm_readdata,
    input  logic                  avm_waitrequest,
    input  logic                  avm_readdatavalid,
    output logic [N-1:0]          a_wren,
    output logic [N-1:0][7:0]     a_data,
    input  logic [N-1:0]          a_full,
    output logic                  b_wren,
    output logic [7:0]            b_data,
    input  logic                  b_full,
    output logic [2:0]            state_dbg
);

    localparam int WW = $clog2(N + 1);
    localparam int BW = $clog2(N);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_REQ  = 3'd1,
        S_WAIT = 3'd2,
        S_PUSH = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t                  state, state_n;
    logic [WW-1:0]           word_idx, word_idx_n;
    logic [BW-1:0]           byte_idx, byte_idx_n;
    logic [8*N-1:0]          shreg, shreg_n;
    logic                    busy_n, done_n, avm_read_n, b_wren_n;
    logic [ADDR_WIDTH-1:0]   avm_address_n;
    logic [N-1:0]            a_wren_n;
    logic [N-1:0][7:0]       a_data_n;
    logic [7:0]              b_data_n;
    logic                    is_b, target_full;
    logic [BW-1:0]           lane;
    logic [WW-1:0]           word_inc;

    // Word N is the vector; every lower word is an A row whose index is the lane.
    assign is_b        = (word_idx == WW'(N));
    assign lane        = word_idx[BW-1:0];
    assign target_full = is_b ? b_full : a_full[lane];
    assign word_inc    = word_idx + WW'(1);
    assign state_dbg   = state;

    always_comb begin
        state_n       = state;
        word_idx_n    = word_idx;
        byte_idx_n    = byte_idx;
        shreg_n       = shreg;
        busy_n        = busy;
        done_n        = 1'b0;
        avm_read_n    = avm_read;
        avm_address_n = avm_address;
        a_wren_n      = '0;
        a_data_n      = '0;
        b_wren_n      = 1'b0;
        b_data_n      = '0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_n       = S_REQ;
                    word_idx_n    = '0;
                    busy_n        = 1'b1;
                    avm_read_n    = 1'b1;
                    avm_address_n = BASE_ADDR;
                end
            end
            S_REQ: begin
                if (!avm_waitrequest) begin
                    state_n    = S_WAIT;
                    avm_read_n = 1'b0;
                end
            end
            S_WAIT: begin
                if (avm_readdatavalid) begin
                    shreg_n    = avm_readdata;
                    byte_idx_n = '0;
                    state_n    = S_PUSH;
                end
            end
            S_PUSH: begin
                // A full target simply holds everything; the byte is retried.
                if (!target_full) begin
                    if (is_b) begin
                        b_wren_n = 1'b1;
                        b_data_n = shreg[7:0];
                    end else begin
                        a_wren_n[lane] = 1'b1;
                        a_data_n[lane] = shreg[7:0];
                    end
                    shreg_n    = shreg >> 8;
                    byte_idx_n = byte_idx + BW'(1);
                    if (byte_idx == BW'(N - 1)) begin
                        if (is_b) begin
                            state_n = S_DONE;
                            busy_n  = 1'b0;
                            done_n  = 1'b1;
                        end else begin
                            word_idx_n    = word_inc;
                            state_n       = S_REQ;
                            avm_read_n    = 1'b1;
                            avm_address_n = BASE_ADDR + ADDR_WIDTH'({word_inc, 3'b000});
                        end
                    end
                end
            end
            S_DONE: begin
                state_n = S_IDLE;
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            word_idx    <= '0;
            byte_idx    <= '0;
            shreg       <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            avm_read    <= 1'b0;
            avm_address <= BASE_ADDR;
            a_wren      <= '0;
            a_data      <= '0;
            b_wren      <= 1'b0;
            b_data      <= '0;
        end else begin
            state       <= state_n;
            word_idx    <= word_idx_n;
            byte_idx    <= byte_idx_n;
            shreg       <= shreg_n;
            busy        <= busy_n;
            done        <= done_n;
            avm_read    <= avm_read_n;
            avm_address <= avm_address_n;
            a_wren      <= a_wren_n;
            a_data      <= a_data_n;
            b_wren      <= b_wren_n;
            b_data      <= b_data_n;
        end
    end

endmodule

// File: tb/tb_mvm_avalon_loader.sv
// Testbench for mvm_avalon_loader.
// The memory contents define the expected result directly. That result is the
// ordered list of (fifo, byte) writes (row 0 bytes 0..7, ..., then vector
// bytes 0..7) and the ordered list of read addresses 8*w. A single
// per-cycle step task plays the Avalon slave, injects stalls, and checks
// every observed write and read against those lists.
module tb_mvm_avalon_loader;

    logic              clk;
    logic              rst_n;
    logic              start;
    logic              busy;
    logic              done;
    logic [31:0]       avm_address;
    logic              avm_read;
    logic [63:0]       avm_readdata;
    logic              avm_waitrequest;
    logic              avm_readdatavalid;
    logic [7:0]        a_wren;
    logic [7:0][7:0]   a_data;
    logic [7:0]        a_full;
    logic              b_wren;
    logic [7:0]        b_data;
    logic              b_full;
    logic [2:0]        state_dbg;

    mvm_avalon_loader dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .start             (start),
        .busy              (busy),
        .done              (done),
        .avm_address       (avm_address),
        .avm_read          (avm_read),
        .avm_readdata      (avm_readdata),
        .avm_waitrequest   (avm_waitrequest),
        .avm_readdatavalid (avm_readdatavalid),
        .a_wren            (a_wren),
        .a_data            (a_data),
        .a_full            (a_full),
        .b_wren            (b_wren),
        .b_data            (b_data),
        .b_full            (b_full),
        .state_dbg         (state_dbg)
    );

    // ---------------- clock ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- model / scoreboard state ----------------
    logic [63:0] mem [0:8];
    logic [11:0] exp_q [$];        // {fifo (8 = B), byte} in write order
    logic [31:0] exp_addr_q [$];   // read addresses in issue order
    int          pass_cnt, total_cnt;
    int          cyc, start_cyc, done_cyc;
    int          reads, dones;
    int          lane_wr [0:8];
    bit          saw_done;
    bit          rd_pending, last_stalled;
    logic [31:0] rd_addr, stalled_addr, ws_addr;
    int          ws_rem;
    int          af_lane, af_len_req, af_rem;
    int          bf_len_req, bf_rem;
    logic [7:0]  fa_last;
    logic        fb_last;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %0h expected %0h at cycle %0d", tag, obs, exp, cyc);
    endtask

    task automatic build_model();
        exp_q.delete();
        exp_addr_q.delete();
        for (int w = 0; w <= 8; w++) begin
            exp_addr_q.push_back(32'(8 * w));
            for (int j = 0; j < 8; j++) exp_q.push_back({4'(w), mem[w][8*j +: 8]});
        end
        reads = 0;
        dones = 0;
        for (int i = 0; i <= 8; i++) lane_wr[i] = 0;
    endtask

    task automatic note_write(input int lane, input logic [7:0] data);
        logic [11:0] e;
        bit          any;
        lane_wr[lane]++;
        any = (exp_q.size() != 0);
        chk("write_expected", any, 1);
        if (any) begin
            e = exp_q.pop_front();
            chk("write_fifo", lane, e[11:8]);
            chk("write_data", data, e[7:0]);
        end
        if (af_len_req > 0 && lane == af_lane && lane_wr[lane] == 3) begin
            af_rem     = af_len_req;
            af_len_req = 0;
        end
    endtask

    // One clock: observe outputs of the current cycle at the falling edge,
    // then drive slave/flow-control inputs for the next rising edge.
    task automatic step();
        logic wr;
        @(negedge clk);
        cyc++;
        for (int i = 0; i < 8; i++) begin
            if (a_wren[i]) begin
                chk("a_wr_while_full", fa_last[i], 1'b0);
                note_write(i, a_data[i]);
            end else begin
                chk("a_idle_lane_zero", a_data[i], 8'h00);
            end
        end
        if (b_wren) begin
            chk("b_wr_while_full", fb_last, 1'b0);
            note_write(8, b_data);
        end
        chk("single_strobe", ($countones({a_wren, b_wren}) <= 1), 1);
        if (avm_read) chk("read_only_when_busy", busy, 1);
        saw_done = done;
        if (done) begin
            dones++;
            done_cyc = cyc;
            chk("busy_low_at_done", busy, 0);
            chk("writes_left_at_done", exp_q.size(), 0);
        end
        // FIFO full flags
        if (af_rem > 0) begin
            a_full = 8'(1 << af_lane);
            af_rem--;
        end else begin
            a_full = 8'h00;
        end
        b_full = (bf_rem > 0);
        if (bf_rem > 0) bf_rem--;
        fa_last = a_full;
        fb_last = b_full;
        // read data one cycle after acceptance
        avm_readdatavalid = 1'b0;
        avm_readdata      = {$urandom, $urandom};
        if (rd_pending) begin
            avm_readdatavalid = 1'b1;
            avm_readdata      = mem[rd_addr[6:3]];
            rd_pending        = 1'b0;
            if (rd_addr == 32'h40 && bf_len_req > 0) begin
                bf_rem     = bf_len_req;
                bf_len_req = 0;
            end
        end
        // request phase
        if (last_stalled) begin
            chk("stall_read_held", avm_read, 1);
            chk("stall_addr_held", avm_address, stalled_addr);
        end
        wr = avm_read && (ws_rem > 0) && (avm_address == ws_addr);
        if (wr) ws_rem--;
        avm_waitrequest = wr;
        last_stalled    = wr;
        stalled_addr    = avm_address;
        if (avm_read && !wr) begin
            bit any;
            reads++;
            any = (exp_addr_q.size() != 0);
            chk("read_expected", any, 1);
            if (any) chk("read_addr", avm_address, exp_addr_q.pop_front());
            rd_pending = 1'b1;
            rd_addr    = avm_address;
        end
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_avm_read"}, avm_read, 0);
        chk({tag, "_avm_address"}, avm_address, 32'h0);
        chk({tag, "_a_wren"}, a_wren, 0);
        chk({tag, "_a_data"}, a_data, 64'h0);
        chk({tag, "_b_wren"}, b_wren, 0);
        chk({tag, "_b_data"}, b_data, 0);
        chk({tag, "_state_idle"}, state_dbg, 3'd0);
    endtask

    task automatic random_mem();
        for (int w = 0; w <= 8; w++) mem[w] = {$urandom, $urandom};
    endtask

    task automatic run_load(input int extra, input bit mid_start);
        bit got;
        build_model();
        got       = 1'b0;
        start     = 1'b1;
        start_cyc = cyc;
        for (int k = 0; k < 400; k++) begin
            step();
            start = mid_start && (cyc == start_cyc + 20);
            if (saw_done) begin
                got = 1'b1;
                break;
            end
            chk("busy_during_load", busy, 1);
        end
        start = 1'b0;
        chk("done_seen", got, 1);
        chk("done_latency", done_cyc - start_cyc, 91 + extra);
        repeat (3) begin
            step();
            chk("idle_after_done", {busy, avm_read}, 2'b00);
        end
        chk("done_once", dones, 1);
        chk("read_count", reads, 9);
        chk("all_writes_seen", exp_q.size(), 0);
        for (int i = 0; i <= 8; i++) chk("writes_per_fifo", lane_wr[i], 8);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        pass_cnt = 0; total_cnt = 0; cyc = 0;
        rst_n = 1'b0; start = 1'b0;
        avm_waitrequest = 1'b0; avm_readdatavalid = 1'b0; avm_readdata = '0;
        a_full = '0; b_full = 1'b0; fa_last = '0; fb_last = 1'b0;
        rd_pending = 1'b0; last_stalled = 1'b0; rd_addr = '0; stalled_addr = '0;
        ws_addr = '0; ws_rem = 0; af_lane = 0; af_len_req = 0; af_rem = 0;
        bf_len_req = 0; bf_rem = 0; saw_done = 1'b0; done_cyc = 0; start_cyc = 0;
        reads = 0; dones = 0;
        for (int i = 0; i <= 8; i++) lane_wr[i] = 0;

        repeat (3) step();
        check_reset("reset");
        rst_n = 1'b1;
        step();

        // basic load with the ramp pattern: byte j of word w = 16w + j
        for (int w = 0; w <= 8; w++)
            for (int j = 0; j < 8; j++) mem[w][8*j +: 8] = 8'(16 * w + j);
        run_load(0, 1'b0);

        // waitrequest held 5 cycles on word 3
        random_mem();
        ws_addr = 32'h18; ws_rem = 5;
        run_load(5, 1'b0);

        // A FIFO 2 full for 4 cycles at byte 3
        random_mem();
        af_lane = 2; af_len_req = 4;
        run_load(4, 1'b0);

        // B FIFO full for 10 cycles at the vector word
        random_mem();
        bf_len_req = 10;
        run_load(10, 1'b0);

        // start while busy is ignored
        random_mem();
        run_load(0, 1'b1);

        // reset during PUSH of row 4
        random_mem();
        build_model();
        start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 0; k < 200; k++) begin
            step();
            if (a_wren[4]) break;
        end
        chk("reached_row4_push", a_wren[4], 1);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check_reset("midop_reset");
        exp_q.delete();
        exp_addr_q.delete();
        avm_readdatavalid = 1'b1;
        avm_readdata      = {$urandom, $urandom};
        repeat (4) begin
            step();
            chk("late_rdv_ignored", {busy, avm_read, a_wren, b_wren}, 11'h0);
        end
        random_mem();
        run_load(0, 1'b0);

        // randomized stall mixes
        for (int r = 0; r < 3; r++) begin
            int ws_len, af_len, bf_len;
            random_mem();
            ws_len     = $urandom_range(1, 6);
            af_len     = $urandom_range(1, 5);
            bf_len     = $urandom_range(1, 6);
            ws_addr    = 32'(8 * $urandom_range(0, 8));
            ws_rem     = ws_len;
            af_lane    = $urandom_range(0, 7);
            af_len_req = af_len;
            bf_len_req = bf_len;
            run_load(ws_len + af_len + bf_len, 1'b0);
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
